// File: rtl/ice_cream_pkg.sv
// Shared encodings for the ice-cream vending controller.
package ice_cream_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        COIN0    = 2'b00,
        COIN1    = 2'b01,
        COIN2    = 2'b10,
        COIN_BAD = 2'b11
    } coin_t;

    // Value in coin units of a legal coin; zero for none or invalid.
    function automatic logic [1:0] coin_value(input coin_t c);
        case (c)
            COIN1:   return 2'd1;
            COIN2:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/rise_detect.sv
// 0->1 edge detector; history resets high so a level already asserted is not an edge.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise_c
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b1;
        else       prev <= d;
    end

    assign rise_c = d & ~prev;

endmodule

// File: rtl/ice_cream_vend.sv
// Coin-operated ice-cream vending controller with ball and change handshakes.
module ice_cream_vend
    import ice_cream_pkg::*;
#(
    parameter int unsigned BALL_PRICE = 2,
    parameter int unsigned MAX_BALLS  = 2,
    parameter int unsigned CREDIT_W   = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               insert,
    input  logic [1:0]                         coins,
    input  logic                               order,
    input  logic                               cancel,
    output logic                               ball_valid,
    input  logic                               ball_ready,
    output logic [$clog2(MAX_BALLS+1)-1:0]     ice_cream_balls,
    output logic                               change_valid,
    output logic [CREDIT_W-1:0]                change,
    input  logic                               change_ready,
    output logic                               coin_reject
);

    localparam int unsigned BALLS_W  = $clog2(MAX_BALLS + 1);
    localparam int unsigned SALE_MAX = MAX_BALLS * BALL_PRICE;

    if (BALL_PRICE < 1 || MAX_BALLS < 1 ||
        (64'd1 << CREDIT_W) <= 64'(SALE_MAX) + 64'd1) begin : g_param_check
        $error("ice_cream_vend: illegal BALL_PRICE/MAX_BALLS/CREDIT_W combination");
    end

    state_t              state, state_next;
    logic [CREDIT_W-1:0] credit, credit_next;
    logic [BALLS_W-1:0]  pending, pending_next;
    logic                coin_reject_next;
    logic                coin_edge_c;
    logic                coin_ok;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] eff_credit;
    logic [CREDIT_W-1:0] credit_after_ball;
    logic [31:0]         quot;

    rise_detect u_rise (
        .clk    (clk),
        .reset  (reset),
        .d      (insert),
        .rise_c (coin_edge_c)
    );

    // Coin acceptance and the credit it produces this cycle.
    always_comb begin
        coin_ok    = coin_edge_c
                     && (coin_t'(coins) == COIN1 || coin_t'(coins) == COIN2)
                     && (state == IDLE || state == COLLECT);
        coin_val   = CREDIT_W'(coin_value(coin_t'(coins)));
        eff_credit = coin_ok ? credit + coin_val : credit;
        quot       = 32'(eff_credit) / BALL_PRICE;
        credit_after_ball = credit - CREDIT_W'(BALL_PRICE);
    end

    // Next-state and datapath updates.
    always_comb begin
        state_next       = state;
        credit_next      = credit;
        pending_next     = pending;
        coin_reject_next = coin_edge_c && (coin_t'(coins) != COIN0) && !coin_ok;

        case (state)
            IDLE: begin
                if (coin_ok) begin
                    credit_next = eff_credit;
                    state_next  = COLLECT;
                end
            end
            COLLECT: begin
                credit_next = eff_credit;
                if (cancel) begin
                    state_next = CHANGE;
                end else if (eff_credit >= CREDIT_W'(SALE_MAX)) begin
                    state_next   = DISPENSE;
                    pending_next = BALLS_W'(MAX_BALLS);
                end else if (order) begin
                    if (eff_credit >= CREDIT_W'(BALL_PRICE)) begin
                        state_next   = DISPENSE;
                        pending_next = (quot >= MAX_BALLS) ? BALLS_W'(MAX_BALLS)
                                                           : BALLS_W'(quot);
                    end else begin
                        state_next = CHANGE;
                    end
                end
            end
            DISPENSE: begin
                if (ball_valid && ball_ready) begin
                    pending_next = pending - BALLS_W'(1);
                    credit_next  = credit_after_ball;
                    if (pending == BALLS_W'(1)) begin
                        state_next = (credit_after_ball != '0) ? CHANGE : IDLE;
                    end
                end
            end
            CHANGE: begin
                if (change_valid && change_ready) begin
                    credit_next = '0;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            credit  <= '0;
            pending <= '0;
        end else begin
            state   <= state_next;
            credit  <= credit_next;
            pending <= pending_next;
        end
    end

    // Outputs registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ball_valid      <= 1'b0;
            ice_cream_balls <= '0;
            change_valid    <= 1'b0;
            change          <= '0;
            coin_reject     <= 1'b0;
        end else begin
            ball_valid      <= (state_next == DISPENSE);
            ice_cream_balls <= (state_next == DISPENSE) ? pending_next : '0;
            change_valid    <= (state_next == CHANGE);
            change          <= (state_next == CHANGE) ? credit_next : '0;
            coin_reject     <= coin_reject_next;
        end
    end

    a_state_legal: assert property (@(posedge clk) disable iff (reset)
        state inside {IDLE, COLLECT, DISPENSE, CHANGE});
    a_pending_max: assert property (@(posedge clk) disable iff (reset)
        pending <= BALLS_W'(MAX_BALLS));
    a_credit_max: assert property (@(posedge clk) disable iff (reset)
        credit <= CREDIT_W'(SALE_MAX + 1));
    a_ball_stable: assert property (@(posedge clk) disable iff (reset)
        ball_valid && !ball_ready |=> ball_valid && $stable(ice_cream_balls));
    a_change_stable: assert property (@(posedge clk) disable iff (reset)
        change_valid && !change_ready |=> change_valid && $stable(change));

endmodule

// File: tb/tb_ice_cream_vend.sv
// Directed bench for ice_cream_vend with default parameters.
module tb_ice_cream_vend;

    logic       clk = 1'b0;
    logic       reset;
    logic       insert;
    logic [1:0] coins;
    logic       order;
    logic       cancel;
    logic       ball_valid;
    logic       ball_ready;
    logic [1:0] ice_cream_balls;
    logic       change_valid;
    logic [3:0] change;
    logic       change_ready;
    logic       coin_reject;

    int vectors     = 0;
    int miscompares = 0;

    ice_cream_vend dut (
        .clk             (clk),
        .reset           (reset),
        .insert          (insert),
        .coins           (coins),
        .order           (order),
        .cancel          (cancel),
        .ball_valid      (ball_valid),
        .ball_ready      (ball_ready),
        .ice_cream_balls (ice_cream_balls),
        .change_valid    (change_valid),
        .change          (change),
        .change_ready    (change_ready),
        .coin_reject     (coin_reject)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic bv, input logic [1:0] balls,
                              input logic cv, input logic [3:0] chg, input logic rej);
        check({tag, ".ball_valid"},      32'(ball_valid),      32'(bv));
        check({tag, ".ice_cream_balls"}, 32'(ice_cream_balls), 32'(balls));
        check({tag, ".change_valid"},    32'(change_valid),    32'(cv));
        check({tag, ".change"},          32'(change),          32'(chg));
        check({tag, ".coin_reject"},     32'(coin_reject),     32'(rej));
    endtask

    // One low cycle then a rising edge with the given coin; insert is left high.
    task automatic coin(input logic [1:0] v);
        insert = 1'b0;
        coins  = 2'b00;
        tick();
        insert = 1'b1;
        coins  = v;
        tick();
    endtask

    initial begin
        reset = 1'b1; insert = 1'b0; coins = 2'b00; order = 1'b0; cancel = 1'b0;
        ball_ready = 1'b0; change_ready = 1'b0;
        tick();
        tick();
        expect_out("reset", 1'b0, 2'd0, 1'b0, 4'd0, 1'b0);
        reset = 1'b0;

        // Four one-unit coins trigger the auto-sale of two balls.
        coin(2'b01); coin(2'b01); coin(2'b01);
        expect_out("four_1_pre", 1'b0, 2'd0, 1'b0, 4'd0, 1'b0);
        coin(2'b01);
        expect_out("four_1_sale", 1'b1, 2'd2, 1'b0, 4'd0, 1'b0);
        tick();
        expect_out("four_1_stall", 1'b1, 2'd2, 1'b0, 4'd0, 1'b0);
        ball_ready = 1'b1;
        tick();
        expect_out("four_1_ball1", 1'b1, 2'd1, 1'b0, 4'd0, 1'b0);
        tick();
        expect_out("four_1_done", 1'b0, 2'd0, 1'b0, 4'd0, 1'b0);
        ball_ready = 1'b0;

        // 2+1 with order: one ball then one unit of change.
        coin(2'b10); coin(2'b01);
        order = 1'b1;
        tick();
        order = 1'b0;
        expect_out("order3_sale", 1'b1, 2'd1, 1'b0, 4'd0, 1'b0);
        ball_ready = 1'b1;
        tick();
        ball_ready = 1'b0;
        expect_out("order3_change", 1'b0, 2'd0, 1'b1, 4'd1, 1'b0);
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        expect_out("order3_idle", 1'b0, 2'd0, 1'b0, 4'd0, 1'b0);

        // Cancel with credit 1 while change_ready stays low.
        coin(2'b01);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        expect_out("cancel_c0", 1'b0, 2'd0, 1'b1, 4'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("cancel_stall", 1'b0, 2'd0, 1'b1, 4'd1, 1'b0);
        end
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        expect_out("cancel_idle", 1'b0, 2'd0, 1'b0, 4'd0, 1'b0);

        // 1,2,2 -> credit 5: auto-sale of two balls, one unit of change.
        coin(2'b01); coin(2'b10); coin(2'b10);
        expect_out("five_sale", 1'b1, 2'd2, 1'b0, 4'd0, 1'b0);
        ball_ready = 1'b1;
        tick();
        expect_out("five_ball1", 1'b1, 2'd1, 1'b0, 4'd0, 1'b0);
        tick();
        ball_ready = 1'b0;
        expect_out("five_change", 1'b0, 2'd0, 1'b1, 4'd1, 1'b0);
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        expect_out("five_idle", 1'b0, 2'd0, 1'b0, 4'd0, 1'b0);

        // Held insert counts once; an invalid coin is rejected for one cycle.
        coin(2'b01);
        for (int i = 0; i < 4; i++) tick();
        expect_out("held_1", 1'b0, 2'd0, 1'b0, 4'd0, 1'b0);
        coin(2'b11);
        expect_out("bad_reject", 1'b0, 2'd0, 1'b0, 4'd0, 1'b1);
        tick();
        expect_out("bad_pulse_end", 1'b0, 2'd0, 1'b0, 4'd0, 1'b0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        expect_out("held_credit", 1'b0, 2'd0, 1'b1, 4'd1, 1'b0);
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;

        // Cancel wins over order with sufficient credit.
        coin(2'b10); coin(2'b01);
        order = 1'b1; cancel = 1'b1;
        tick();
        order = 1'b0; cancel = 1'b0;
        expect_out("cancel_prio", 1'b0, 2'd0, 1'b1, 4'd3, 1'b0);
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;

        // Order with credit below one ball goes straight to change.
        coin(2'b01);
        order = 1'b1;
        tick();
        order = 1'b0;
        expect_out("order_short", 1'b0, 2'd0, 1'b1, 4'd1, 1'b0);
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        expect_out("order_short_idle", 1'b0, 2'd0, 1'b0, 4'd0, 1'b0);

        // Coin during DISPENSE is rejected, then reset abandons the sale.
        coin(2'b10); coin(2'b10);
        expect_out("rst_sale", 1'b1, 2'd2, 1'b0, 4'd0, 1'b0);
        coin(2'b01);
        expect_out("disp_reject", 1'b1, 2'd2, 1'b0, 4'd0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_out("rst_mid", 1'b0, 2'd0, 1'b0, 4'd0, 1'b0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        expect_out("rst_idle_cancel", 1'b0, 2'd0, 1'b0, 4'd0, 1'b0);
        coin(2'b01);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        expect_out("rst_credit", 1'b0, 2'd0, 1'b1, 4'd1, 1'b0);
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        expect_out("final_idle", 1'b0, 2'd0, 1'b0, 4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
